// File: rtl/btn_press_classifier_if.sv
// Gesture interface between the debounce/edge stage and the press classifier.
// Carries the raw press/release pulses in and the classified gesture pulses out.
// No handshake: every signal is a single-cycle pulse or a level, never stalled.
interface btn_press_classifier_if;

   // Debounced edge pulses from the upstream debounce stage
   logic i_btn_posedge;
   logic i_btn_negedge;

   // Classified gesture pulses and status levels
   logic o_short_press;
   logic o_long_press;
   logic o_double_press;
   logic o_repeat;
   logic o_hold;
   logic o_busy;

   // Upstream side: drives the edge pulses and watches the gestures
   modport master (
      output i_btn_posedge,
      output i_btn_negedge,
      input  o_short_press,
      input  o_long_press,
      input  o_double_press,
      input  o_repeat,
      input  o_hold,
      input  o_busy
   );

   // Classifier side: consumes the edge pulses and produces the gestures
   modport slave (
      input  i_btn_posedge,
      input  i_btn_negedge,
      output o_short_press,
      output o_long_press,
      output o_double_press,
      output o_repeat,
      output o_hold,
      output o_busy
   );

endinterface

// File: rtl/btn_press_classifier.sv
// Classifies debounced press/release pulses into short, long and double presses.
// Latency: every output is registered, one clock after the edge that decides it.
// Backpressure: none; gesture pulses are one cycle wide and cannot be stalled.
//
// Optional auto-repeat while a long press is held: define BTN_AUTO_REPEAT_EN.
// Without it o_repeat is tied low and no repeat counter exists.
//
// LONG_CYCLES, DOUBLE_GAP_CYCLES and REPEAT_CYCLES must each be >= 2: the
// terminal compares below use (N-1) and assume a state lasts at least 2 cycles.
module btn_press_classifier #(
   parameter int LONG_CYCLES       = 100_000_000,
   parameter int DOUBLE_GAP_CYCLES = 30_000_000,
   parameter int REPEAT_CYCLES     = 20_000_000
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   btn_press_classifier_if.slave btn
);

   // The one gesture counter must reach the largest of the three periods.
   localparam int MAX_LG  = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
   localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_ALL) + 1;

   // Terminal counts: the counter is 0 in the first cycle of a state, so the
   // N-th cycle in the state is the one where it reads N-1.
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HOLD = 3'd2,
      WAIT2     = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic             short_q;
   logic             long_q;
   logic             double_q;
   logic             hold_q;
   logic             busy_q;

   // A press and release in the same cycle is a glitch: both are dropped.
   logic             pos_v;
   logic             neg_v;

   assign pos_v = btn.i_btn_posedge & ~btn.i_btn_negedge;
   assign neg_v = btn.i_btn_negedge & ~btn.i_btn_posedge;

   // Gesture FSM: state, shared gesture counter and all registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         hold_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // Pulses last one cycle; the counter free-runs unless a state
         // change below clears it.
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         cnt      <= cnt + 1'b1;

         case (state)
            IDLE: begin
               // Release with nothing pressed is meaningless and dropped.
               if (pos_v) begin
                  state  <= PRESS1;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end

            PRESS1: begin
               // Release takes priority over reaching the long threshold.
               if (neg_v) begin
                  state <= WAIT2;
                  cnt   <= '0;
               end else if (cnt == LONG_TC) begin
                  state  <= LONG_HOLD;
                  cnt    <= '0;
                  long_q <= 1'b1;
                  hold_q <= 1'b1;
               end
            end

            LONG_HOLD: begin
               // The long press was already reported; release just ends it.
               if (neg_v) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  hold_q <= 1'b0;
                  busy_q <= 1'b0;
               end
            end

            WAIT2: begin
               // A second press on the very last gap cycle still counts.
               if (pos_v) begin
                  state <= PRESS2;
                  cnt   <= '0;
               end else if (cnt == GAP_TC) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  short_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end

            PRESS2: begin
               // No timeout here: however long the second hold, it is a double.
               if (neg_v) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  double_q <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               cnt    <= '0;
               hold_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign btn.o_short_press  = short_q;
   assign btn.o_long_press   = long_q;
   assign btn.o_double_press = double_q;
   assign btn.o_hold         = hold_q;
   assign btn.o_busy         = busy_q;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int               REP_W  = $clog2(REPEAT_CYCLES) + 1;
   localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             repeat_q;

   // Repeat timer: starts at 0 on the first LONG_HOLD cycle, so the first
   // repeat lands REPEAT_CYCLES after the long-press pulse. A release on the
   // terminal cycle wins and swallows that repeat.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rep_cnt  <= '0;
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= 1'b0;
         if (state == LONG_HOLD && !neg_v) begin
            if (rep_cnt == REP_TC) begin
               rep_cnt  <= '0;
               repeat_q <= 1'b1;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
            end
         end else begin
            rep_cnt <= '0;
         end
      end
   end

   assign btn.o_repeat = repeat_q;
`else
   assign btn.o_repeat = 1'b0;
`endif

endmodule
